// File: rtl/frac_sad_select.sv
// Accumulates per-row fractional-candidate SADs over a block, then scans the
// block totals one candidate per cycle and presents the minimum over valid/ready.
module frac_sad_select #(
  parameter int N_CAND = 6,
  parameter int SAD_W  = 10,
  parameter int ROWS   = 8,
  parameter int ACC_W  = 13,
  parameter int IDX_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CAND*SAD_W-1:0]   sad_in,
  input  logic                      sad_valid,
  input  logic                      blk_start,
  output logic                      in_ready,
  output logic [ACC_W-1:0]          best_sad,
  output logic [IDX_W-1:0]          best_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_restart
);

  localparam int ROW_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc      [N_CAND];
  logic [ACC_W-1:0]   acc_next [N_CAND];
  logic [ACC_W-1:0]   sad_ext  [N_CAND];
  logic [ROW_W-1:0]   rows;
  logic [ROW_W-1:0]   rows_next;
  logic [IDX_W-1:0]   scan_idx;
  logic [ACC_W-1:0]   cand;
  logic               in_accept_state;
  logic               accept;
  logic               load;
  logic               add;
  logic               block_done;
  logic               take_cand;

  assign in_accept_state = (state == IDLE) || (state == ACCUM);
  assign accept          = sad_valid && in_ready && in_accept_state;
  // The first row after IDLE always starts a block; blk_start only matters mid-block.
  assign load            = accept && ((state == IDLE) || blk_start);
  assign add             = accept && !load;
  assign rows_next       = load ? ROW_W'(1) : rows + ROW_W'(1);
  assign block_done      = accept && (rows_next == ROW_W'(ROWS));

  for (genvar gi = 0; gi < N_CAND; gi++) begin : g_acc
    assign sad_ext[gi]  = ACC_W'(sad_in[gi*SAD_W +: SAD_W]);
    assign acc_next[gi] = load ? sad_ext[gi] :
                          add  ? acc[gi] + sad_ext[gi] :
                                 acc[gi];
  end

  assign cand      = acc[scan_idx];
  // Strict less-than keeps the lowest index on ties.
  assign take_cand = (scan_idx == '0) || (cand < best_sad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CAND; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < N_CAND; i++) acc[i] <= acc_next[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rows        <= '0;
      scan_idx    <= '0;
      best_sad    <= '0;
      best_idx    <= '0;
      out_valid   <= 1'b0;
      err_restart <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      err_restart <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            rows        <= rows_next;
            err_restart <= (state == ACCUM) && blk_start;
            if (block_done) begin
              state    <= SCAN;
              scan_idx <= '0;
              in_ready <= 1'b0;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end

        SCAN: begin
          if (take_cand) begin
            best_sad <= cand;
            best_idx <= scan_idx;
          end
          if (scan_idx == IDX_W'(N_CAND - 1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end

        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            rows      <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
